mips_multiciclo_ctrl: RTL and testbench

- Parametrised multi-cycle control sequencer for the MIPS datapath. It is the successor to the single-cycle combinational control path.
- A Moore FSM steps each instruction through fetch/decode/execute/memory/writeback. It waits on a memory ready handshake, times out hung accesses, traps illegal opcodes and counts retired instructions.
- It drives the shared-memory multi-cycle datapath: IR, PC, register bank, ALU, and muxes for A/B sources and PC source.

---
 rtl/mips_multiciclo_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_mips_multiciclo_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multiciclo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mips_multiciclo_ctrl
// Description : Moore control sequencer for the shared-memory multi-cycle MIPS
//               datapath. It steps each instruction through fetch, decode,
//               execute, memory and writeback. It also waits on a memory ready
//               handshake, times out hung accesses, traps illegal opcodes and
//               counts retired instructions.
// Ports       :
//   clk, rst_n          clock (rising edge), async active-low reset
//   op                  IR[31:26], meaningful from DECODE onward
//   zero                ALU zero flag, qualifies pc_write_cond
//   mem_ready           memory access completes this cycle
//   pc_en               pc_write | (pc_write_cond & zero)
//   iord, mem_read,
//   mem_write, ir_write memory side strobes / address select
//   reg_write, reg_dst,
//   mem_to_reg          register bank write controls
//   alu_src_a/b, alu_op ALU operand selects and operation
//   pc_src              PC source select
//   illegal, bus_err    sticky trap flags
//   retired             completed instruction count (wraps)
//   state               current state encoding, for debug
// Revision    : 1.0 - initial release
// ============================================================================
module mips_multiciclo_ctrl #(
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned CNT_W    = 32,
  parameter bit          HAS_JUMP = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_ERROR  = 4'd15
  } state_t;

  state_t           r_state;
  logic [7:0]       r_wait;
  logic [CNT_W-1:0] r_retired;
  logic             r_illegal;
  logic             r_bus_err;

  logic             w_pc_write;
  logic             w_pc_write_cond;
  logic             w_wait_hit;

  // The counter holds the number of cycles already spent without mem_ready, so
  // the last allowed cycle is the one where it equals WAIT_MAX-1. A mem_ready
  // in that same cycle still wins over the timeout.
  assign w_wait_hit = (r_wait == 8'(WAIT_MAX - 1));

  // r_wait defaults to zero every cycle and only counts while a memory state
  // is being held, which gives the clear-on-entry behaviour for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_wait    <= 8'd0;
      r_retired <= '0;
      r_illegal <= 1'b0;
      r_bus_err <= 1'b0;
    end else begin
      r_wait <= 8'd0;
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            r_state <= S_DECODE;
          end else if (w_wait_hit) begin
            r_state   <= S_ERROR;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_DECODE: begin
          case (op)
            6'b100011, 6'b101011: r_state <= S_MEMADR;
            6'b000000:            r_state <= S_EXEC;
            6'b000100:            r_state <= S_BRANCH;
            6'b001000:            r_state <= S_ADDIEX;
            6'b000010: begin
              if (HAS_JUMP) begin
                r_state <= S_JUMP;
              end else begin
                r_state   <= S_ERROR;
                r_illegal <= 1'b1;
              end
            end
            default: begin
              r_state   <= S_ERROR;
              r_illegal <= 1'b1;
            end
          endcase
        end
        // Only lw/sw reach MEMADR; op[3] separates sw (101011) from lw (100011).
        S_MEMADR: r_state <= op[3] ? S_MEMWR : S_MEMRD;
        S_MEMRD: begin
          if (mem_ready) begin
            r_state <= S_MEMWB;
          end else if (w_wait_hit) begin
            r_state   <= S_ERROR;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_MEMWR: begin
          if (mem_ready) begin
            r_state   <= S_FETCH;
            r_retired <= r_retired + CNT_W'(1);
          end else if (w_wait_hit) begin
            r_state   <= S_ERROR;
            r_bus_err <= 1'b1;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_EXEC:   r_state <= S_ALUWB;
        S_ADDIEX: r_state <= S_ADDIWB;
        S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
          r_state   <= S_FETCH;
          r_retired <= r_retired + CNT_W'(1);
        end
        S_ERROR: r_state <= S_ERROR;
        default: r_state <= S_ERROR;
      endcase
    end
  end

  // Moore decode from the state register. ir_write/pc_write in FETCH are
  // additionally qualified by mem_ready so the IR and PC load exactly once.
  always_comb begin
    iord            = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    ir_write        = 1'b0;
    reg_write       = 1'b0;
    reg_dst         = 1'b0;
    mem_to_reg      = 1'b0;
    alu_src_a       = 1'b0;
    alu_src_b       = 2'b00;
    alu_op          = 3'b000;
    pc_src          = 2'b00;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read   = 1'b1;
        alu_src_b  = 2'b01;
        ir_write   = mem_ready;
        w_pc_write = mem_ready;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a       = 1'b1;
        alu_op          = 3'b001;
        w_pc_write_cond = 1'b1;
        pc_src          = 2'b01;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        w_pc_write = 1'b1;
        pc_src     = 2'b10;
      end
      default: ;
    endcase
  end

  assign pc_en   = w_pc_write | (w_pc_write_cond & zero);
  assign illegal = r_illegal;
  assign bus_err = r_bus_err;
  assign retired = r_retired;
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_mips_multiciclo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_multiciclo_ctrl
// Description : Directed self-checking bench for mips_multiciclo_ctrl. Unit A
//               uses default parameters; unit B uses WAIT_MAX=4, CNT_W=4,
//               HAS_JUMP=0. Inputs change and outputs are sampled on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multiciclo_ctrl;

  localparam logic [5:0] c_op_r    = 6'b000000;
  localparam logic [5:0] c_op_lw   = 6'b100011;
  localparam logic [5:0] c_op_sw   = 6'b101011;
  localparam logic [5:0] c_op_beq  = 6'b000100;
  localparam logic [5:0] c_op_addi = 6'b001000;
  localparam logic [5:0] c_op_j    = 6'b000010;
  localparam logic [5:0] c_op_bad  = 6'b111111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Unit A signals
  logic        rst_n_a, zero_a, ready_a;
  logic [5:0]  op_a;
  logic        pc_en_a, iord_a, mem_read_a, mem_write_a, ir_write_a;
  logic        reg_write_a, reg_dst_a, mem_to_reg_a, alu_src_a_a;
  logic [1:0]  alu_src_b_a, pc_src_a;
  logic [2:0]  alu_op_a;
  logic        illegal_a, bus_err_a;
  logic [31:0] retired_a;
  logic [3:0]  state_a;

  // Unit B signals
  logic        rst_n_b, zero_b, ready_b;
  logic [5:0]  op_b;
  logic        pc_en_b, iord_b, mem_read_b, mem_write_b, ir_write_b;
  logic        reg_write_b, reg_dst_b, mem_to_reg_b, alu_src_a_b;
  logic [1:0]  alu_src_b_b, pc_src_b;
  logic [2:0]  alu_op_b;
  logic        illegal_b, bus_err_b;
  logic [3:0]  retired_b;
  logic [3:0]  state_b;

  mips_multiciclo_ctrl #(.WAIT_MAX(8), .CNT_W(32), .HAS_JUMP(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .op(op_a), .zero(zero_a), .mem_ready(ready_a),
    .pc_en(pc_en_a), .iord(iord_a), .mem_read(mem_read_a), .mem_write(mem_write_a),
    .ir_write(ir_write_a), .reg_write(reg_write_a), .reg_dst(reg_dst_a),
    .mem_to_reg(mem_to_reg_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
    .alu_op(alu_op_a), .pc_src(pc_src_a), .illegal(illegal_a), .bus_err(bus_err_a),
    .retired(retired_a), .state(state_a)
  );

  mips_multiciclo_ctrl #(.WAIT_MAX(4), .CNT_W(4), .HAS_JUMP(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .op(op_b), .zero(zero_b), .mem_ready(ready_b),
    .pc_en(pc_en_b), .iord(iord_b), .mem_read(mem_read_b), .mem_write(mem_write_b),
    .ir_write(ir_write_b), .reg_write(reg_write_b), .reg_dst(reg_dst_b),
    .mem_to_reg(mem_to_reg_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
    .alu_op(alu_op_b), .pc_src(pc_src_b), .illegal(illegal_b), .bus_err(bus_err_b),
    .retired(retired_b), .state(state_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Aggregated strobes of unit A / B: {mem_read, mem_write, ir_write, reg_write, pc_en, iord}
  function automatic logic [5:0] strobes_a();
    return {mem_read_a, mem_write_a, ir_write_a, reg_write_a, pc_en_a, iord_a};
  endfunction
  function automatic logic [5:0] strobes_b();
    return {mem_read_b, mem_write_b, ir_write_b, reg_write_b, pc_en_b, iord_b};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_a = 1'b0; op_a = c_op_r; zero_a = 1'b0; ready_a = 1'b1;
    rst_n_b = 1'b0; op_b = c_op_sw; zero_b = 1'b0; ready_b = 1'b1;
    tick(); tick();

    // ---------------- Unit A: reset state ----------------
    chk_eq("rst_state",   state_a, 4'd0);
    chk_eq("rst_retired", retired_a, 0);
    chk_eq("rst_illegal", illegal_a, 0);
    chk_eq("rst_bus_err", bus_err_a, 0);
    chk_eq("rst_strobes", strobes_a(), 6'b0);
    chk_eq("rst_alu",     {alu_src_b_a, alu_op_a, pc_src_a}, 7'b0);

    // ---------------- R-type, mem_ready tied 1 ----------------
    rst_n_a = 1'b1;
    tick();
    chk_eq("r_fetch_state", state_a, 4'd1);
    chk_eq("r_fetch_strb",  strobes_a(), 6'b101010);
    chk_eq("r_fetch_srcb",  alu_src_b_a, 2'b01);
    tick();
    chk_eq("r_dec_state",   state_a, 4'd2);
    chk_eq("r_dec_strb",    strobes_a(), 6'b0);
    chk_eq("r_dec_srcb",    alu_src_b_a, 2'b11);
    tick();
    chk_eq("r_exec_state",  state_a, 4'd7);
    chk_eq("r_exec_alu",    {alu_src_a_a, alu_src_b_a, alu_op_a}, {1'b1, 2'b00, 3'b010});
    tick();
    chk_eq("r_aluwb_state", state_a, 4'd8);
    chk_eq("r_aluwb_wr",    {reg_write_a, reg_dst_a, mem_to_reg_a}, 3'b110);
    chk_eq("r_aluwb_ret",   retired_a, 0);
    op_a = c_op_lw;
    tick();
    chk_eq("r_back_fetch",  state_a, 4'd1);
    chk_eq("r_retired",     retired_a, 1);

    // ---------------- lw with 3 wait cycles in MEMRD ----------------
    tick();
    chk_eq("lw_dec",        state_a, 4'd2);
    tick();
    chk_eq("lw_memadr",     state_a, 4'd3);
    chk_eq("lw_adr_alu",    {alu_src_a_a, alu_src_b_a, alu_op_a}, {1'b1, 2'b10, 3'b000});
    ready_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq("lw_memrd_state", state_a, 4'd4);
      chk_eq("lw_memrd_strb",  strobes_a(), 6'b100001);
      if (i == 3) ready_a = 1'b1;
    end
    tick();
    chk_eq("lw_memwb_state", state_a, 4'd5);
    chk_eq("lw_memwb_wr",    {reg_write_a, reg_dst_a, mem_to_reg_a}, 3'b101);
    op_a = c_op_beq;
    tick();
    chk_eq("lw_retired",     retired_a, 2);
    chk_eq("lw_bus_err",     bus_err_a, 0);

    // ---------------- beq taken / not taken ----------------
    tick();
    chk_eq("beq1_dec", state_a, 4'd2);
    zero_a = 1'b1;
    tick();
    chk_eq("beq1_state", state_a, 4'd9);
    chk_eq("beq1_pcen",  pc_en_a, 1);
    chk_eq("beq1_ctl",   {alu_src_a_a, alu_src_b_a, alu_op_a, pc_src_a}, {1'b1, 2'b00, 3'b001, 2'b01});
    tick();
    chk_eq("beq1_retired", retired_a, 3);
    tick();
    zero_a = 1'b0;
    tick();
    chk_eq("beq0_state", state_a, 4'd9);
    chk_eq("beq0_pcen",  pc_en_a, 0);
    chk_eq("beq0_pcsrc", pc_src_a, 2'b01);
    op_a = c_op_j;
    tick();
    chk_eq("beq0_retired", retired_a, 4);

    // ---------------- jump (legal on unit A) ----------------
    tick();
    tick();
    chk_eq("j_state", state_a, 4'd12);
    chk_eq("j_pc",    {pc_en_a, pc_src_a}, {1'b1, 2'b10});
    op_a = c_op_bad;
    tick();
    chk_eq("j_retired", retired_a, 5);

    // ---------------- illegal opcode ----------------
    tick();
    tick();
    chk_eq("ill_state",   state_a, 4'd15);
    chk_eq("ill_flag",    illegal_a, 1);
    for (int i = 0; i < 20; i++) begin
      ready_a = i[0];
      zero_a  = 1'b1;
      tick();
      chk_eq("ill_hold_state", state_a, 4'd15);
      chk_eq("ill_hold_strb",  strobes_a(), 6'b0);
    end
    chk_eq("ill_sticky",  illegal_a, 1);
    chk_eq("ill_retired", retired_a, 5);
    rst_n_a = 1'b0;
    #1;
    chk_eq("ill_rst_flag",  illegal_a, 0);
    chk_eq("ill_rst_state", state_a, 4'd0);
    chk_eq("ill_rst_ret",   retired_a, 0);

    // ---------------- Unit B: sw timeout (WAIT_MAX=4) ----------------
    rst_n_b = 1'b1;
    tick();
    chk_eq("swto_fetch", state_b, 4'd1);
    tick();
    tick();
    chk_eq("swto_memadr", state_b, 4'd3);
    ready_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq("swto_memwr_state", state_b, 4'd6);
      chk_eq("swto_memwr_strb",  strobes_b(), 6'b010001);
    end
    tick();
    chk_eq("swto_err_state", state_b, 4'd15);
    chk_eq("swto_bus_err",   bus_err_b, 1);
    chk_eq("swto_strb",      strobes_b(), 6'b0);
    chk_eq("swto_retired",   retired_b, 0);

    // ---------------- sw with ready on the last allowed cycle ----------------
    rst_n_b = 1'b0;
    ready_b = 1'b1;
    tick();
    chk_eq("sw_rst_bus_err", bus_err_b, 0);
    rst_n_b = 1'b1;
    tick(); tick(); tick();
    chk_eq("sw_memadr", state_b, 4'd3);
    ready_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq("sw_memwr_state", state_b, 4'd6);
      if (i == 3) ready_b = 1'b1;
    end
    tick();
    chk_eq("sw_ok_state",   state_b, 4'd1);
    chk_eq("sw_ok_bus_err", bus_err_b, 0);
    chk_eq("sw_ok_retired", retired_b, 1);

    // ---------------- 17 addi, 4-bit counter wraps ----------------
    rst_n_b = 1'b0;
    op_b    = c_op_addi;
    tick();
    rst_n_b = 1'b1;
    tick(); tick(); tick();
    chk_eq("addi_ex_state", state_b, 4'd10);
    chk_eq("addi_ex_alu",   {alu_src_a_b, alu_src_b_b, alu_op_b}, {1'b1, 2'b10, 3'b000});
    tick();
    chk_eq("addi_wb_state", state_b, 4'd11);
    chk_eq("addi_wb_wr",    {reg_write_b, reg_dst_b, mem_to_reg_b}, 3'b100);
    repeat (57) tick();
    chk_eq("addi15_state", state_b, 4'd1);
    chk_eq("addi15_ret",   retired_b, 15);
    repeat (4) tick();
    chk_eq("addi16_ret",   retired_b, 0);
    repeat (4) tick();
    chk_eq("addi17_ret",   retired_b, 1);

    // ---------------- jump illegal when HAS_JUMP=0 ----------------
    op_b = c_op_j;
    tick();
    tick();
    chk_eq("nj_state",   state_b, 4'd15);
    chk_eq("nj_illegal", illegal_b, 1);
    chk_eq("nj_bus_err", bus_err_b, 0);
    chk_eq("nj_pcen",    pc_en_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
